// File: rtl/byte_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : byte_serial_adder (+ kogge_stone_adder_8bits slice)
// Purpose  : WIDTH-bit adder built from one 8-bit Kogge-Stone slice reused
//            LSB-to-MSB, one byte per clock, behind a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================

module kogge_stone_adder_8bits (
  input  logic [7:0] operand_a,
  input  logic [7:0] operand_b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);
  logic [7:0] w_p;
  logic [7:0] w_g0;
  logic [7:0] w_g1;
  logic [7:0] w_g2;
  logic [7:0] w_g3;
  logic [7:2] w_p1;
  logic [7:4] w_p2;

  assign w_p = operand_a ^ operand_b;
  // cin is folded into bit 0's generate so the prefix tree yields carries directly
  assign w_g0 = {operand_a[7:1] & operand_b[7:1],
                 (operand_a[0] & operand_b[0]) | (w_p[0] & cin)};

  always_comb begin
    w_g1 = w_g0;
    for (int i = 1; i < 8; i++) begin
      w_g1[i] = w_g0[i] | (w_p[i] & w_g0[i-1]);
    end
    for (int i = 2; i < 8; i++) begin
      w_p1[i] = w_p[i] & w_p[i-1];
    end
  end

  always_comb begin
    w_g2 = w_g1;
    for (int i = 2; i < 8; i++) begin
      w_g2[i] = w_g1[i] | (w_p1[i] & w_g1[i-2]);
    end
    for (int i = 4; i < 8; i++) begin
      w_p2[i] = w_p1[i] & w_p1[i-2];
    end
  end

  always_comb begin
    w_g3 = w_g2;
    for (int i = 4; i < 8; i++) begin
      w_g3[i] = w_g2[i] | (w_p2[i] & w_g2[i-4]);
    end
  end

  assign sum  = w_p ^ {w_g3[6:0], cin};
  assign cout = w_g3[7];
endmodule

module byte_serial_adder #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);
  localparam int NUM_BYTES = WIDTH / 8;
  localparam int IDX_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NUM_BYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [IDX_W-1:0] r_idx;
  logic             r_carry;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             r_out_valid;

  logic [7:0]       w_slice_sum;
  logic             w_slice_cout;

  kogge_stone_adder_8bits u_slice (
    .operand_a (r_a[8*r_idx +: 8]),
    .operand_b (r_b[8*r_idx +: 8]),
    .cin       (r_carry),
    .sum       (w_slice_sum),
    .cout      (w_slice_cout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_carry     <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= operand_a;
            r_b     <= operand_b;
            r_carry <= cin;
            r_idx   <= '0;
            r_sum   <= '0;
            r_state <= S_CALC;
          end
        end
        S_CALC: begin
          r_sum[8*r_idx +: 8] <= w_slice_sum;
          r_carry             <= w_slice_cout;
          if (r_idx == c_last_idx) begin
            // Signed overflow: like-signed operands producing an opposite-signed sum
            r_cout      <= w_slice_cout;
            r_ovf       <= (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                           (w_slice_sum[7] != r_a[WIDTH-1]);
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE) & rst_n;
  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign overflow  = r_ovf;
endmodule

`default_nettype wire

// File: tb/tb_byte_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_byte_serial_adder
// Purpose  : Scoreboard bench for byte_serial_adder at WIDTH = 8, 32 and 64.
// Revision : 1.0 - initial release
// ============================================================================
module tb_byte_serial_adder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // index 0: WIDTH=8, index 1: WIDTH=32, index 2: WIDTH=64
  logic        in_valid_v  [3];
  logic        out_ready_v [3];
  logic        cin_v       [3];
  logic [63:0] a_v         [3];
  logic [63:0] b_v         [3];
  logic        in_ready_v  [3];
  logic        out_valid_v [3];
  logic        cout_v      [3];
  logic        ovf_v       [3];
  logic [63:0] sum_v       [3];
  logic [7:0]  sum8;
  logic [31:0] sum32;
  logic [63:0] sum64;

  assign sum_v[0] = {56'd0, sum8};
  assign sum_v[1] = {32'd0, sum32};
  assign sum_v[2] = sum64;

  byte_serial_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .operand_a(a_v[0][7:0]), .operand_b(b_v[0][7:0]), .cin(cin_v[0]),
    .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
    .sum(sum8), .cout(cout_v[0]), .overflow(ovf_v[0]));

  byte_serial_adder #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .operand_a(a_v[1][31:0]), .operand_b(b_v[1][31:0]), .cin(cin_v[1]),
    .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
    .sum(sum32), .cout(cout_v[1]), .overflow(ovf_v[1]));

  byte_serial_adder #(.WIDTH(64)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
    .operand_a(a_v[2]), .operand_b(b_v[2]), .cin(cin_v[2]),
    .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]),
    .sum(sum64), .cout(cout_v[2]), .overflow(ovf_v[2]));

  typedef struct {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    int          acc;
  } exp_t;

  exp_t sb[$];

  function automatic int nbytes(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 4 : 8);
  endfunction

  function automatic exp_t mk(input logic [63:0] s, input logic c, input logic o, input int acc);
    exp_t e;
    e.sum = s; e.cout = c; e.ovf = o; e.acc = acc;
    return e;
  endfunction

  function automatic exp_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                 input logic c, input int acc);
    logic [63:0] mask;
    logic [64:0] full;
    exp_t        e;
    mask  = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    full  = {1'b0, a & mask} + {1'b0, b & mask} + {64'd0, c};
    e.sum = full[63:0] & mask;
    e.cout = full[w];
    e.ovf = (a[w-1] == b[w-1]) && (e.sum[w-1] != a[w-1]);
    e.acc = acc;
    return e;
  endfunction

  function automatic logic [63:0] rand64();
    int r;
    r = $urandom_range(0, 7);
    if (r == 0) return '1;
    if (r == 1) return '0;
    return {$urandom(), $urandom()};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int k, output int n);
    n = 0;
    while (out_valid_v[k] !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid_v[k] = 1'b0; out_ready_v[k] = 1'b1; cin_v[k] = 1'b0;
      a_v[k] = '0; b_v[k] = '0;
    end
    repeat (3) tick();
    for (int k = 0; k < 3; k++) begin
      checks++; if (in_ready_v[k] !== 1'b0) begin errors++; $display("FAIL reset_in_ready[%0d]: got %b expected 0", k, in_ready_v[k]); end
      checks++; if (out_valid_v[k] !== 1'b0) begin errors++; $display("FAIL reset_out_valid[%0d]: got %b expected 0", k, out_valid_v[k]); end
      checks++; if (sum_v[k] !== 64'd0) begin errors++; $display("FAIL reset_sum[%0d]: got %h expected 0", k, sum_v[k]); end
      checks++; if (cout_v[k] !== 1'b0 || ovf_v[k] !== 1'b0) begin errors++; $display("FAIL reset_flags[%0d]: got cout=%b ovf=%b expected 0 0", k, cout_v[k], ovf_v[k]); end
    end
    rst_n = 1'b1;
    tick();
    checks++; if (in_ready_v[1] !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b expected 1", in_ready_v[1]); end
  endtask

  // Directed vectors on the 32-bit instance with out_ready held high.
  task automatic test_vectors();
    logic [31:0] ta [4];
    logic [31:0] tb [4];
    logic        tc [4];
    logic [31:0] ts [4];
    logic        tco[4];
    logic        tov[4];
    exp_t        e;
    int          n;
    ta = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000};
    tb = '{32'h0000_0002, 32'h0000_0000, 32'h0000_0001, 32'h8000_0000};
    tc = '{1'b0, 1'b1, 1'b0, 1'b0};
    ts = '{32'h0000_0003, 32'h0000_0000, 32'h8000_0000, 32'h0000_0000};
    tco = '{1'b0, 1'b1, 1'b0, 1'b1};
    tov = '{1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      a_v[1] = {32'd0, ta[i]}; b_v[1] = {32'd0, tb[i]}; cin_v[1] = tc[i];
      in_valid_v[1] = 1'b1; out_ready_v[1] = 1'b1;
      checks++; if (in_ready_v[1] !== 1'b1) begin errors++; $display("FAIL vec%0d_in_ready: got %b expected 1", i, in_ready_v[1]); end
      sb.push_back(mk({32'd0, ts[i]}, tco[i], tov[i], cyc + 1));
      tick();
      in_valid_v[1] = 1'b0;
      wait_valid(1, n);
      e = sb.pop_front();
      checks++;
      if (n >= 30) begin errors++; $display("FAIL vec%0d_timeout: got no out_valid expected within 30 cycles", i); end
      else if (cyc - e.acc != 4) begin errors++; $display("FAIL vec%0d_latency: got %0d expected 4", i, cyc - e.acc); end
      checks++; if (sum_v[1] !== e.sum) begin errors++; $display("FAIL vec%0d_sum: got %h expected %h", i, sum_v[1], e.sum); end
      checks++; if (cout_v[1] !== e.cout) begin errors++; $display("FAIL vec%0d_cout: got %b expected %b", i, cout_v[1], e.cout); end
      checks++; if (ovf_v[1] !== e.ovf) begin errors++; $display("FAIL vec%0d_ovf: got %b expected %b", i, ovf_v[1], e.ovf); end
      tick();
      checks++; if (out_valid_v[1] !== 1'b0) begin errors++; $display("FAIL vec%0d_pulse: got out_valid=%b expected 0", i, out_valid_v[1]); end
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    int   n;
    out_ready_v[1] = 1'b0;
    a_v[1] = 64'h0F0F_0F0F; b_v[1] = 64'h0101_0101; cin_v[1] = 1'b0;
    in_valid_v[1] = 1'b1;
    sb.push_back(mk(64'h1010_1010, 1'b0, 1'b0, cyc + 1));
    tick();
    in_valid_v[1] = 1'b0;
    wait_valid(1, n);
    checks++; if (n >= 30) begin errors++; $display("FAIL bp_timeout: got no out_valid expected within 30 cycles"); end
    a_v[1] = 64'hAAAA_0000; b_v[1] = 64'h0000_5555; cin_v[1] = 1'b1;
    in_valid_v[1] = 1'b1;
    e = sb[0];
    for (int i = 0; i < 4; i++) begin
      checks++; if (out_valid_v[1] !== 1'b1) begin errors++; $display("FAIL bp_hold_valid%0d: got %b expected 1", i, out_valid_v[1]); end
      checks++; if (in_ready_v[1] !== 1'b0) begin errors++; $display("FAIL bp_in_ready%0d: got %b expected 0", i, in_ready_v[1]); end
      checks++; if (sum_v[1] !== e.sum || cout_v[1] !== e.cout || ovf_v[1] !== e.ovf) begin
        errors++; $display("FAIL bp_hold_data%0d: got %h/%b/%b expected %h/%b/%b", i, sum_v[1], cout_v[1], ovf_v[1], e.sum, e.cout, e.ovf);
      end
      if (i < 3) tick();
    end
    out_ready_v[1] = 1'b1;
    void'(sb.pop_front());
    tick();
    checks++; if (out_valid_v[1] !== 1'b0 || in_ready_v[1] !== 1'b1) begin
      errors++; $display("FAIL bp_release: got out_valid=%b in_ready=%b expected 0 1", out_valid_v[1], in_ready_v[1]);
    end
    sb.push_back(mk(64'hAAAA_5556, 1'b0, 1'b0, cyc + 1));
    tick();
    in_valid_v[1] = 1'b0;
    wait_valid(1, n);
    e = sb.pop_front();
    checks++;
    if (n >= 30) begin errors++; $display("FAIL bp_pending_timeout: got no out_valid expected within 30 cycles"); end
    else if (sum_v[1] !== e.sum || cout_v[1] !== e.cout) begin
      errors++; $display("FAIL bp_pending_result: got %h/%b expected %h/%b", sum_v[1], cout_v[1], e.sum, e.cout);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int   last_acc;
    int   gap_bad;
    int   nacc;
    exp_t e;
    last_acc = -1; gap_bad = 0; nacc = 0;
    in_valid_v[1] = 1'b1; out_ready_v[1] = 1'b1;
    for (int c = 0; c < 26; c++) begin
      if (out_valid_v[1] === 1'b1 && sb.size() > 0) begin
        e = sb.pop_front();
        checks++; if (sum_v[1] !== e.sum || cout_v[1] !== e.cout || ovf_v[1] !== e.ovf) begin
          errors++; $display("FAIL b2b_result: got %h/%b/%b expected %h/%b/%b", sum_v[1], cout_v[1], ovf_v[1], e.sum, e.cout, e.ovf);
        end
      end
      a_v[1] = {32'd0, $urandom()}; b_v[1] = {32'd0, $urandom()}; cin_v[1] = 1'($urandom_range(0, 1));
      if (in_ready_v[1] === 1'b1) begin
        sb.push_back(model(32, a_v[1], b_v[1], cin_v[1], cyc + 1));
        if (last_acc >= 0 && (cyc + 1 - last_acc) != 6) gap_bad++;
        last_acc = cyc + 1;
        nacc++;
      end
      tick();
    end
    checks++; if (gap_bad != 0 || nacc < 4) begin
      errors++; $display("FAIL b2b_throughput: got %0d accepts with %0d bad gaps expected >=4 accepts spaced 6", nacc, gap_bad);
    end
    in_valid_v[1] = 1'b0;
    repeat (8) tick();
    sb.delete();
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int   n;
    int   pulses;
    a_v[1] = 64'h1234_5678; b_v[1] = 64'h1111_1111; cin_v[1] = 1'b0;
    in_valid_v[1] = 1'b1; out_ready_v[1] = 1'b1;
    tick();
    in_valid_v[1] = 1'b0;
    repeat (2) tick();
    rst_n = 1'b0;
    tick();
    checks++; if (out_valid_v[1] !== 1'b0 || sum_v[1] !== 64'd0 || cout_v[1] !== 1'b0 || ovf_v[1] !== 1'b0) begin
      errors++; $display("FAIL midrst_clear: got v=%b sum=%h c=%b o=%b expected 0 0 0 0", out_valid_v[1], sum_v[1], cout_v[1], ovf_v[1]);
    end
    checks++; if (in_ready_v[1] !== 1'b0) begin errors++; $display("FAIL midrst_in_ready: got %b expected 0", in_ready_v[1]); end
    tick();
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid_v[1] === 1'b1) pulses++;
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL midrst_no_pulse: got %0d pulses expected 0", pulses); end
    in_valid_v[1] = 1'b1;
    sb.push_back(mk(64'h2345_6789, 1'b0, 1'b0, cyc + 1));
    tick();
    in_valid_v[1] = 1'b0;
    wait_valid(1, n);
    e = sb.pop_front();
    checks++;
    if (n >= 30) begin errors++; $display("FAIL midrst_rerun_timeout: got no out_valid expected within 30 cycles"); end
    else if (sum_v[1] !== e.sum) begin errors++; $display("FAIL midrst_rerun_sum: got %h expected %h", sum_v[1], e.sum); end
    tick();
  endtask

  task automatic test_random(input int k, input int nops);
    int          w, nb, done, issued, guard;
    logic        seen;
    logic [63:0] ra, rb;
    exp_t        e;
    nb = nbytes(k); w = 8 * nb;
    done = 0; issued = 0; guard = 0; seen = 1'b0;
    sb.delete();
    while (done < nops && guard < nops * 40) begin
      if (out_valid_v[k] === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL rand%0d_spurious: got out_valid=1 expected no pending result", w);
        end else begin
          e = sb[0];
          if (sum_v[k] !== e.sum || cout_v[k] !== e.cout || ovf_v[k] !== e.ovf) begin
            errors++; $display("FAIL rand%0d_result: got %h/%b/%b expected %h/%b/%b", w, sum_v[k], cout_v[k], ovf_v[k], e.sum, e.cout, e.ovf);
          end
          if (!seen) begin
            seen = 1'b1;
            checks++; if (cyc - e.acc != nb) begin errors++; $display("FAIL rand%0d_latency: got %0d expected %0d", w, cyc - e.acc, nb); end
          end
        end
      end
      out_ready_v[k] = ($urandom_range(0, 3) != 0);
      if (out_valid_v[k] === 1'b1 && out_ready_v[k] && sb.size() > 0) begin
        void'(sb.pop_front());
        seen = 1'b0;
        done++;
      end
      in_valid_v[k] = (issued < nops) && ($urandom_range(0, 2) != 0);
      ra = rand64(); rb = rand64();
      a_v[k] = ra; b_v[k] = rb; cin_v[k] = 1'($urandom_range(0, 1));
      if (in_valid_v[k] && in_ready_v[k] === 1'b1) begin
        sb.push_back(model(w, ra, rb, cin_v[k], cyc + 1));
        issued++;
      end
      tick();
      guard++;
    end
    checks++; if (done != nops) begin errors++; $display("FAIL rand%0d_complete: got %0d results expected %0d", w, done, nops); end
    in_valid_v[k] = 1'b0; out_ready_v[k] = 1'b1;
    repeat (2) tick();
    sb.delete();
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random(0, 2000);
    test_random(1, 2000);
    test_random(2, 2000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
